// File: rtl/pim_pkg.sv
// Shared definitions for the PIM instruction dispatcher.
// - Instruction width and opcode field constants for the CU encoding.
// - Field offsets used to decode read/write/ALU words.
// - FSM state type for the dispatcher issue sequencer.
// - is_illegal(): flags the two reserved non-ALU opcodes (3'b010, 3'b011).
package pim_pkg;

  localparam int INSTR_W  = 45;
  localparam int ALU_BIT  = 44;
  localparam int ADDR_LSB = 32;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;

  localparam logic [2:0] OP_READ  = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // A word is illegal when it is not an ALU op and its opcode is neither
  // a read nor a write.
  function automatic logic is_illegal(input logic [INSTR_W-1:0] instr);
    logic [2:0] op;
    op = instr[ALU_BIT -: 3];
    return !op[2] && (op != OP_READ) && (op != OP_WRITE);
  endfunction

endpackage

// File: rtl/pim_instr_fifo.sv
// Circular synchronous FIFO holding queued PIM instructions.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push is only accepted when not full (even if a pop happens in the same
// cycle); a pop is only accepted when not empty. There is no bypass: a word
// pushed into an empty FIFO is visible on pop_data_o the following cycle.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   push_i/push_data_i  write request and data
//   pop_i/pop_data_o    read request and head-of-queue data (combinational)
//   full_o, empty_o, level_o  status; level_o is the current occupancy
import pim_pkg::*;

module pim_instr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 45
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  // Same index with opposite wrap bits means the write side is a full lap ahead.
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/pim_instr_dispatcher.sv
// Instruction buffer and issue sequencer in front of the PIM control unit.
// Host words are queued in pim_instr_fifo and issued one at a time: the head
// is popped into cu_instruction, cu_operation_enable is held for EN_CYCLES
// cycles, then the FSM waits for cu_ready to fall (CU started) and rise
// again (CU done) before the next issue.
//
// Handshake: a host transfer happens on a rising edge where in_valid and
// in_ready are both high; in_ready is high whenever the FIFO is not full,
// and in_valid may drop at any time without a transfer.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_instr/in_valid/in_ready   host push interface
//   cu_instruction        registered word to the CU, held until next issue
//   cu_operation_enable   start pulse, EN_CYCLES cycles wide
//   cu_ready              CU idle/done indication
//   fill_level            FIFO occupancy
//   busy                  FSM not in IDLE
//   issued_count          completed instructions, wraps at 16 bits
//   illegal_instr         sticky illegal-opcode flag (PIM_DISPATCH_CHECK_EN only)
//   dbg_state             current FSM state (pim_pkg::state_e encoding)
//
// Build option PIM_DISPATCH_CHECK_EN: illegal opcodes are dropped at pop,
// never reach the CU, and set illegal_instr until reset.
import pim_pkg::*;

module pim_instr_dispatcher #(
  parameter int DEPTH     = 8,
  parameter int INSTR_W   = 45,
  parameter int EN_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_W-1:0]     in_instr,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [INSTR_W-1:0]     cu_instruction,
  output logic                   cu_operation_enable,
  input  logic                   cu_ready,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   busy,
  output logic [15:0]            issued_count,
`ifdef PIM_DISPATCH_CHECK_EN
  output logic                   illegal_instr,
`endif
  output logic [1:0]             dbg_state
);

  localparam int CW = $clog2(EN_CYCLES + 1);

  state_e               state_q;
  logic [CW-1:0]        en_cnt_q;
  logic [INSTR_W-1:0]   instr_q;
  logic                 en_q;
  logic [15:0]          count_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [INSTR_W-1:0]   fifo_head;
  logic                 push;
  logic                 pop;
  logic                 drop;

  assign push = in_valid && !fifo_full;
  // Pop only when idle and the CU is ready; an illegal head is popped too,
  // but then dropped instead of issued.
  assign pop  = (state_q == ST_IDLE) && !fifo_empty && cu_ready;

`ifdef PIM_DISPATCH_CHECK_EN
  logic illegal_q;
  assign drop          = is_illegal(fifo_head);
  assign illegal_instr = illegal_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              illegal_q <= 1'b0;
    else if (pop && drop)  illegal_q <= 1'b1;
  end
`else
  assign drop = 1'b0;
`endif

  pim_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .push_data_i (in_instr),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fill_level)
  );

  // Issue sequencer. en_cnt_q counts the enable cycles still owed, including
  // the current one, so enable drops on the edge where it reads 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      en_cnt_q <= '0;
      instr_q  <= '0;
      en_q     <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop && !drop) begin
            instr_q  <= fifo_head;
            en_q     <= 1'b1;
            en_cnt_q <= CW'(EN_CYCLES);
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (en_cnt_q == CW'(1)) begin
            en_q    <= 1'b0;
            state_q <= ST_WAIT_ACK;
          end else begin
            en_cnt_q <= en_cnt_q - CW'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (!cu_ready) state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (cu_ready) begin
            count_q <= count_q + 16'd1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready            = !fifo_full;
  assign cu_instruction      = instr_q;
  assign cu_operation_enable = en_q;
  assign busy                = (state_q != ST_IDLE);
  assign issued_count        = count_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_pim_instr_dispatcher.sv
// Directed testbench for pim_instr_dispatcher with an inline CU/memory model.
import pim_pkg::*;

module tb_pim_instr_dispatcher;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [44:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [44:0] cu_instr;
  logic        cu_en;
  logic        cu_ready;
  logic [3:0]  fill;
  logic        busy;
  logic [15:0] issued;
  logic [1:0]  dbg;
`ifdef PIM_DISPATCH_CHECK_EN
  logic        illegal;
`endif

  pim_instr_dispatcher #(.DEPTH(8), .INSTR_W(45), .EN_CYCLES(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_instr            (in_instr),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .cu_instruction      (cu_instr),
    .cu_operation_enable (cu_en),
    .cu_ready            (cu_ready),
    .fill_level          (fill),
    .busy                (busy),
    .issued_count        (issued),
`ifdef PIM_DISPATCH_CHECK_EN
    .illegal_instr       (illegal),
`endif
    .dbg_state           (dbg)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [44:0] exp_q[$];
  logic [31:0] cu_mem [1024];
  logic [31:0] last_rdata;

  // ---------------- driver tasks ----------------
  task automatic push(input logic [44:0] d, output bit acc);
    in_instr = d;
    in_valid = 1'b1;
    acc      = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // CU model: waits for an enable, measures its width, then drops cu_ready
  // for three cycles and raises it again. clean stays 1 only if the word is
  // stable, enable stays low, and the FSM sits in WAIT_DONE while busy.
  task automatic cu_serve(output logic [44:0] got, output int waited,
                          output int width, output bit clean);
    waited = 0; width = 0; clean = 1'b1; got = '0;
    while (!cu_en && waited < 40) begin
      @(posedge clk); #1; waited++;
    end
    if (!cu_en) begin
      clean = 1'b0;
      return;
    end
    got = cu_instr;
    while (cu_en && width < 20) begin
      width++;
      if (cu_instr !== got) clean = 1'b0;
      @(posedge clk); #1;
    end
    cu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (cu_en !== 1'b0 || cu_instr !== got || dbg !== ST_WAIT_DONE) clean = 1'b0;
    end
    cu_ready = 1'b1;
    @(posedge clk); #1;
    if (cu_instr !== got) clean = 1'b0;
    if (got[44:42] == OP_WRITE)     cu_mem[got[41:32]] = got[31:0];
    else if (got[44:42] == OP_READ) last_rdata = cu_mem[got[41:32]];
  endtask

  task automatic apply_reset();
    rst = 1'b0; in_valid = 1'b0; cu_ready = 1'b1;
    exp_q.delete();
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    in_instr = '0;
    apply_reset();
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (cu_instr !== 45'd0) begin n_fail++; $display("FAIL reset_cu_instr got %h want 0", cu_instr); end
    n_checks++; if (cu_en !== 1'b0)     begin n_fail++; $display("FAIL reset_enable got %b want 0", cu_en); end
    n_checks++; if (fill !== 4'd0)      begin n_fail++; $display("FAIL reset_fill got %0d want 0", fill); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (issued !== 16'd0)   begin n_fail++; $display("FAIL reset_issued got %0d want 0", issued); end
    n_checks++; if (dbg !== ST_IDLE)    begin n_fail++; $display("FAIL reset_state got %0d want 0", dbg); end
`ifdef PIM_DISPATCH_CHECK_EN
    n_checks++; if (illegal !== 1'b0)   begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal); end
`endif
  endtask

  task automatic test_write_read();
    logic [44:0] w, r, got;
    int waited, width;
    bit acc, clean;
    w = {3'b001, 10'h38A, 32'h12345678};
    r = {3'b000, 10'h38A, 32'h00000000};
    push(w, acc);
    n_checks++; if (cu_en !== 1'b0) begin n_fail++; $display("FAIL latency_after_push got %b want 0", cu_en); end
    push(r, acc);
    n_checks++; if (cu_en !== 1'b1) begin n_fail++; $display("FAIL latency_second_edge got %b want 1", cu_en); end
    cu_serve(got, waited, width, clean);
    n_checks++; if (got !== w)   begin n_fail++; $display("FAIL wr_instr got %h want %h", got, w); end
    n_checks++; if (width !== 2) begin n_fail++; $display("FAIL wr_en_width got %0d want 2", width); end
    n_checks++; if (!clean)      begin n_fail++; $display("FAIL wr_hold got 0 want 1"); end
    cu_serve(got, waited, width, clean);
    n_checks++; if (got !== r)    begin n_fail++; $display("FAIL rd_instr got %h want %h", got, r); end
    n_checks++; if (width !== 2)  begin n_fail++; $display("FAIL rd_en_width got %0d want 2", width); end
    n_checks++; if (waited !== 1) begin n_fail++; $display("FAIL rd_back_to_back_gap got %0d want 1", waited); end
    n_checks++; if (!clean)       begin n_fail++; $display("FAIL rd_hold got 0 want 1"); end
    n_checks++; if (last_rdata !== 32'h12345678) begin n_fail++; $display("FAIL rd_data got %h want 12345678", last_rdata); end
    n_checks++; if (issued !== 16'd2) begin n_fail++; $display("FAIL wr_rd_issued got %0d want 2", issued); end
  endtask

  task automatic test_alu();
    logic [44:0] a, got;
    int waited, width;
    bit acc, clean;
    a = {1'b1, 2'b01, 10'h000, 10'h38A, 10'h045, 12'h000};
    push(a, acc);
    cu_serve(got, waited, width, clean);
    n_checks++; if (got !== a)    begin n_fail++; $display("FAIL alu_instr got %h want %h", got, a); end
    n_checks++; if (!clean)       begin n_fail++; $display("FAIL alu_stable got 0 want 1"); end
    n_checks++; if (issued !== 16'd3) begin n_fail++; $display("FAIL alu_issued got %0d want 3", issued); end
  endtask

  task automatic test_fill();
    logic [44:0] d, got, e;
    int waited, width;
    bit acc, clean;
    cu_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d = {3'b001, 10'(i + 16), 32'hA0000000 | 32'(i)};
      push(d, acc);
      if (acc) exp_q.push_back(d);
      if (i == 7) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
      end
      if (i == 8) begin
        n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL fill_ninth_accepted got %b want 0", acc); end
      end
    end
    n_checks++; if (fill !== 4'd8) begin n_fail++; $display("FAIL fill_level got %0d want 8", fill); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_busy got %b want 0", busy); end
    cu_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      cu_serve(got, waited, width, clean);
      n_checks++; if (got !== e || !clean) begin n_fail++; $display("FAIL fill_drain_%0d got %h want %h clean %b", i, got, e, clean); end
    end
    n_checks++; if (issued !== 16'd11) begin n_fail++; $display("FAIL fill_issued got %0d want 11", issued); end
  endtask

  task automatic test_back_to_back();
    logic [44:0] d, got, e;
    int waited, width, pushed;
    bit acc, clean;
    cu_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = {3'b001, 10'(k), 32'hC0DE0000 | 32'(k)};
      push(d, acc);
      exp_q.push_back(d);
    end
    n_checks++; if (fill !== 4'd3) begin n_fail++; $display("FAIL simul_pre_fill got %0d want 3", fill); end
    // Push and pop on the same edge.
    d = {3'b001, 10'd3, 32'hC0DE0003};
    in_instr = d; in_valid = 1'b1; cu_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(d);
    n_checks++; if (fill !== 4'd3) begin n_fail++; $display("FAIL simul_fill got %0d want 3", fill); end
    n_checks++; if (cu_en !== 1'b1) begin n_fail++; $display("FAIL simul_enable got %b want 1", cu_en); end
    pushed = 4;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cu_serve(got, waited, width, clean);
      n_checks++; if (got !== e || !clean) begin n_fail++; $display("FAIL order_%0d got %h want %h clean %b", pushed, got, e, clean); end
      if (pushed < 20) begin
        d = {3'b001, 10'(pushed), 32'hC0DE0000 | 32'(pushed)};
        push(d, acc);
        exp_q.push_back(d);
        pushed++;
      end
    end
    n_checks++; if (issued !== 16'd31) begin n_fail++; $display("FAIL order_issued got %0d want 31", issued); end
  endtask

  task automatic test_reset_mid();
    logic [44:0] d, got;
    int waited, width;
    bit acc, clean, seen;
    cu_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d = {3'b000, 10'(200 + k), 32'h0};
      push(d, acc);
    end
    cu_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (dbg !== ST_WAIT_DONE) begin n_fail++; $display("FAIL mid_state got %0d want 3", dbg); end
    n_checks++; if (fill !== 4'd4) begin n_fail++; $display("FAIL mid_fill got %0d want 4", fill); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (cu_en !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_enable got %b want 0", cu_en); end
    n_checks++; if (cu_instr !== 45'd0) begin n_fail++; $display("FAIL mid_rst_instr got %h want 0", cu_instr); end
    n_checks++; if (fill !== 4'd0)      begin n_fail++; $display("FAIL mid_rst_fill got %0d want 0", fill); end
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    n_checks++; if (issued !== 16'd0)   begin n_fail++; $display("FAIL mid_rst_issued got %0d want 0", issued); end
    cu_ready = 1'b1;
    #2 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (cu_en) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_issue got %b want 0", seen); end
    d = {3'b000, 10'h001, 32'h0};
    push(d, acc);
    cu_serve(got, waited, width, clean);
    n_checks++; if (got !== d || !clean) begin n_fail++; $display("FAIL mid_new_issue got %h want %h", got, d); end
    n_checks++; if (issued !== 16'd1) begin n_fail++; $display("FAIL mid_issued got %0d want 1", issued); end
  endtask

  task automatic test_illegal();
    logic [44:0] bad, rd, got;
    int waited, width;
    bit acc, clean;
    apply_reset();
    bad = {3'b010, 42'h0000000ABCD};
    rd  = {3'b000, 10'h38A, 32'h0};
    push(bad, acc);
    push(rd, acc);
`ifdef PIM_DISPATCH_CHECK_EN
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag got %b want 1", illegal); end
    n_checks++; if (cu_en !== 1'b0)   begin n_fail++; $display("FAIL illegal_enable got %b want 0", cu_en); end
    cu_serve(got, waited, width, clean);
    n_checks++; if (got !== rd || !clean) begin n_fail++; $display("FAIL illegal_next_read got %h want %h", got, rd); end
    n_checks++; if (issued !== 16'd1) begin n_fail++; $display("FAIL illegal_issued got %0d want 1", issued); end
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky got %b want 1", illegal); end
`else
    cu_serve(got, waited, width, clean);
    n_checks++; if (got !== bad || !clean) begin n_fail++; $display("FAIL unchecked_pass got %h want %h", got, bad); end
    cu_serve(got, waited, width, clean);
    n_checks++; if (got !== rd || !clean) begin n_fail++; $display("FAIL unchecked_read got %h want %h", got, rd); end
    n_checks++; if (issued !== 16'd2) begin n_fail++; $display("FAIL unchecked_issued got %0d want 2", issued); end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    in_valid = 1'b0;
    cu_ready = 1'b1;
    last_rdata = '0;
    test_reset();
    test_write_read();
    test_alu();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
